ws2812_frame_ctrl: RTL and testbench
====================================

Name: ws2812_frame_ctrl

Overview:
- Frame scheduler for the WS2812 bit serializer.
- Holds a LED_NUM x 24-bit pixel buffer written by a host port.
- On a manual request or auto-refresh tick, streams pixels in index order to the serializer over a valid/ready handshake, waits for the serializer to go idle, then holds the line-latch (reset) gap.
- Sits between colour-generation logic (keys, patterns) and the serializer that drives WS2812_Di.

Parameters:
- LED_NUM, 8, number of LEDs on the chain (>=1).
- ADDR_W, 3, pixel address width; 2**ADDR_W >= LED_NUM.
- CLK_FRE, 27_000_000, clk frequency in Hz.
- RESET_CYCLES, CLK_FRE/1_000_000*80, latch gap length in clk cycles (80 us, >50 us).
- REFRESH_CYCLES, CLK_FRE/100, auto-refresh period in clk cycles (100 Hz).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- wr_en, input, 1, pixel write strobe.
- wr_addr, input, ADDR_W, pixel index; writes with wr_addr >= LED_NUM are ignored.
- wr_data, input, 24, pixel colour, GRB order ([23:16]=G, [15:8]=R, [7:0]=B).
- frame_start, input, 1, one-cycle request to send a frame.
- auto_en, input, 1, enables periodic refresh.
- busy, output, 1, high from frame accept through end of latch gap.
- frame_done, output, 1, one-cycle pulse at end of latch gap.
- pix_valid, output, 1, pix_data valid to serializer.
- pix_data, output, 24, pixel to serialize (passed through unmodified).
- pix_ready, input, 1, serializer accepts pixel when high with pix_valid.
- ser_idle, input, 1, serializer has finished all queued bits.

Behaviour:
- Reset (rst high at a clk edge):
  - State IDLE; busy, frame_done, pix_valid = 0; pix_data = 0.
  - Pending flag, pixel index, latch counter and refresh timer = 0.
  - Buffer contents are not cleared; they are undefined until written.
  - Reset mid-frame: pix_valid is low the next cycle; no frame_done pulse.
- Write port: buffer[wr_addr] <= wr_data on clk when wr_en is high. Writes are accepted in every state. A write to an index not yet sent in the current frame appears in that frame.
- Request sources:
  - frame_start high.
  - Refresh tick: the timer counts every cycle while auto_en=1 and is held at 0 while auto_en=0. The tick fires when the timer equals REFRESH_CYCLES-1, then the timer wraps to 0.
  - A request in IDLE starts a frame. A request while busy sets pending; multiple requests collapse into one.
- States:
  - IDLE: on request, go to LOAD, index=0, busy=1 the next cycle.
  - LOAD: 1-cycle synchronous buffer read of buffer[index]; go to SEND.
  - SEND: pix_valid=1 and pix_data=buffer[index], both held stable until pix_ready=1.
    - On handshake with index<LED_NUM-1: index+1, go to LOAD, pix_valid=0.
    - On handshake with index=LED_NUM-1: go to DRAIN.
  - DRAIN: wait for ser_idle=1, sampled from the first cycle in DRAIN; then clear the latch counter and go to LATCH.
  - LATCH: count RESET_CYCLES cycles (counter 0..RESET_CYCLES-1). On the final count, pulse frame_done=1 for one cycle.
    - If pending: clear pending, index=0, go to LOAD; busy stays 1.
    - Else go to IDLE with busy=0 in the same cycle as the frame_done pulse.
- Latency:
  - frame_start at cycle 0 gives busy=1 at cycle 1 and pix_valid=1 at cycle 2.
  - Inter-pixel gap: pix_valid is low for exactly 1 cycle after each handshake.
- Simultaneous events:
  - frame_start and a refresh tick in the same cycle count as one request.
  - A request in the final LATCH cycle sets pending, so the next frame starts back-to-back.
- Throughput: with pix_ready tied high, a frame takes 2*LED_NUM + (DRAIN cycles) + RESET_CYCLES cycles.

Test Plan:
1. Use LED_NUM=4, RESET_CYCLES=16, REFRESH_CYCLES=200. Write 0x0F0000, 0x000F00, 0x00000F, 0xFFFFFF to addresses 0..3. Pulse frame_start with pix_ready=1 and ser_idle=1. Required: pixels appear in that order, handshakes at cycles 2, 4, 6, 8, and frame_done is one pulse with busy falling in the same cycle.
2. Hold pix_ready low for 5 cycles on pixel 1. Required: pix_valid and pix_data=0x000F00 stay stable for those 5 cycles, then exactly 4 handshakes total.
3. Hold ser_idle low for 10 cycles after the last handshake. Required: the latch gap starts only after ser_idle rises and lasts 16 cycles before frame_done.
4. Pulse frame_start 3 times while busy. Required: exactly one extra frame, starting directly after frame_done with busy never dropping, and 2 frame_done pulses total.
5. Set auto_en=1 for 1000 cycles with no frame_start. Required: frames start at ticks on cycles 199, 399, 599, 799, 999; an auto_en drop resets the timer.
6. Assert rst mid-SEND on pixel 2, and separately write to wr_addr=5. Required: after rst, all outputs are 0 and the state is idle; the write to wr_addr=5 leaves buffer contents unchanged.

Source files
------------

// File: rtl/ws2812_frame_ctrl.sv
// Frame scheduler for a WS2812 chain: holds the pixel buffer and streams one frame per request
// to the bit serializer, then holds the line-latch gap before reporting completion.
module ws2812_frame_ctrl #(
  parameter int unsigned LED_NUM        = 8,
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned CLK_FRE        = 27_000_000,
  parameter int unsigned RESET_CYCLES   = CLK_FRE / 1_000_000 * 80,
  parameter int unsigned REFRESH_CYCLES = CLK_FRE / 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              frame_start,
  input  logic              auto_en,
  output logic              busy,
  output logic              frame_done,
  output logic              pix_valid,
  output logic [23:0]       pix_data,
  input  logic              pix_ready,
  input  logic              ser_idle
);

  localparam int unsigned Depth  = 1 << ADDR_W;
  localparam int unsigned LatchW = $clog2(RESET_CYCLES + 1);
  localparam int unsigned TimerW = $clog2(REFRESH_CYCLES + 1);

  localparam logic [ADDR_W-1:0] LastIdx   = ADDR_W'(LED_NUM - 1);
  localparam logic [ADDR_W:0]   NumLeds   = (ADDR_W + 1)'(LED_NUM);
  localparam logic [LatchW-1:0] LatchLast = LatchW'(RESET_CYCLES - 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(REFRESH_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StDrain,
    StLatch
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                pend_q, pend_d;
  logic [LatchW-1:0]   latch_cnt_q, latch_cnt_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                frame_done_q, frame_done_d;
  logic [23:0]         pix_data_q;
  logic                tick;
  logic                req;

  // Buffer is deliberately not reset; entries past LED_NUM are never written or read.
  logic [23:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < NumLeds)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_data_q <= 24'd0;
    end else if (state_q == StLoad) begin
      pix_data_q <= mem[idx_q];
    end
  end

  always_comb begin
    tick    = auto_en && (timer_q == TimerLast);
    timer_d = (!auto_en || tick) ? '0 : timer_q + TimerW'(1);
    req     = frame_start || tick;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pend_d       = pend_q;
    latch_cnt_d  = latch_cnt_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StLoad;
          idx_d   = '0;
        end
      end
      StLoad: begin
        pend_d  = pend_q || req;
        state_d = StSend;
      end
      StSend: begin
        pend_d = pend_q || req;
        if (pix_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDrain;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = StLoad;
          end
        end
      end
      StDrain: begin
        pend_d = pend_q || req;
        if (ser_idle) begin
          latch_cnt_d = '0;
          state_d     = StLatch;
        end
      end
      StLatch: begin
        if (latch_cnt_q == LatchLast) begin
          frame_done_d = 1'b1;
          // A request landing on the last gap cycle still chains the next frame.
          if (pend_q || req) begin
            pend_d  = 1'b0;
            idx_d   = '0;
            state_d = StLoad;
          end else begin
            state_d = StIdle;
          end
        end else begin
          latch_cnt_d = latch_cnt_q + LatchW'(1);
          pend_d      = pend_q || req;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      latch_cnt_q  <= '0;
      timer_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      latch_cnt_q  <= latch_cnt_d;
      timer_q      <= timer_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign pix_valid  = (state_q == StSend);
  assign pix_data   = pix_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Bench for ws2812_frame_ctrl: directed scenarios with literal timing expectations plus a
// randomized run checked every cycle against a frame-level reference model.
module tb_ws2812_frame_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 3;
  localparam int unsigned RC = 16;
  localparam int unsigned RF = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0]   wr_data = '0;
  logic          frame_start = 1'b0;
  logic          auto_en = 1'b0;
  logic          pix_ready = 1'b1;
  logic          ser_idle = 1'b1;
  logic          busy, frame_done, pix_valid;
  logic [23:0]   pix_data;

  ws2812_frame_ctrl #(
    .LED_NUM       (N),
    .ADDR_W        (AW),
    .CLK_FRE       (27_000_000),
    .RESET_CYCLES  (RC),
    .REFRESH_CYCLES(RF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_start(frame_start),
    .auto_en    (auto_en),
    .busy       (busy),
    .frame_done (frame_done),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .ser_idle   (ser_idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: frame phases with a pixel cursor, a gap countdown and a request latch.
  localparam int PIdle  = 0;
  localparam int PFetch = 1;
  localparam int PShow  = 2;
  localparam int PFlush = 3;
  localparam int PGap   = 4;

  logic [23:0] m_buf [N];
  int          m_ph = PIdle;
  int          m_pos = 0;
  int          m_gap_left = 0;
  int          m_since_en = 0;
  bit          m_want = 1'b0;
  bit          m_done = 1'b0;
  logic [23:0] m_pix = '0;

  always @(posedge clk) begin
    int          ph, pos, gap, since;
    bit          want, done, tick, req;
    logic [23:0] pix;
    ph = m_ph; pos = m_pos; gap = m_gap_left; since = m_since_en;
    want = m_want; pix = m_pix; done = 1'b0;
    if (rst) begin
      ph = PIdle; pos = 0; gap = 0; since = 0; want = 1'b0; pix = '0;
    end else begin
      tick  = auto_en && (m_since_en == RF - 1);
      since = (auto_en && !tick) ? m_since_en + 1 : 0;
      req   = frame_start || tick;
      if (m_ph != PIdle) want = want || req;
      case (m_ph)
        PIdle:  if (req) begin ph = PFetch; pos = 0; end
        PFetch: begin pix = m_buf[m_pos]; ph = PShow; end
        PShow:  if (pix_ready) begin
                  if (m_pos == N - 1) ph = PFlush;
                  else begin pos = m_pos + 1; ph = PFetch; end
                end
        PFlush: if (ser_idle) begin ph = PGap; gap = RC; end
        PGap:   if (m_gap_left == 1) begin
                  done = 1'b1;
                  if (want) begin want = 1'b0; pos = 0; ph = PFetch; end
                  else ph = PIdle;
                end else gap = m_gap_left - 1;
        default: ph = PIdle;
      endcase
    end
    if (wr_en && wr_addr < N) m_buf[wr_addr] <= wr_data;
    m_ph <= ph; m_pos <= pos; m_gap_left <= gap; m_since_en <= since;
    m_want <= want; m_done <= done; m_pix <= pix;
  end

  // Per-cycle compare plus event logs used by the directed literal checks.
  int          hs_cyc[$];
  logic [23:0] hs_dat[$];
  int          done_cyc[$];
  bit          done_busy[$];
  int          rise_cyc[$];
  bit          busy_prev = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_ph != PIdle));
      check("pix_valid", 32'(pix_valid), 32'(m_ph == PShow));
      check("frame_done", 32'(frame_done), 32'(m_done));
      if (m_ph == PShow) check("pix_data", 32'(pix_data), 32'(m_pix));
    end
    if (pix_valid && pix_ready) begin
      hs_cyc.push_back(cyc);
      hs_dat.push_back(pix_data);
    end
    if (frame_done) begin
      done_cyc.push_back(cyc);
      done_busy.push_back(busy);
    end
    if (busy && !busy_prev) rise_cyc.push_back(cyc);
    busy_prev <= busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    hs_cyc.delete(); hs_dat.delete(); done_cyc.delete(); done_busy.delete(); rise_cyc.delete();
  endtask

  task automatic pulse_start(output int t0);
    frame_start = 1'b1;
    t0 = cyc;
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int bound);
    for (int k = 0; k < bound && done_cyc.size() < n; k++) step();
    if (done_cyc.size() < n) check("wait_done_timeout", 32'(done_cyc.size()), 32'(n));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  logic [23:0] pix [N];
  int t0, a0;

  initial begin
    pix[0] = 24'h0F0000; pix[1] = 24'h000F00; pix[2] = 24'h00000F; pix[3] = 24'hFFFFFF;
    rst = 1'b1;
    repeat (3) step();
    check_idle_outputs("reset");
    chk_en = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = pix[i];
      step();
    end
    wr_en = 1'b0;
    step();

    // Basic frame with ready and idle held high.
    clear_logs();
    pulse_start(t0);
    wait_done(1, 100);
    repeat (10) step();
    check("t1_hs_count", 32'(hs_cyc.size()), 32'd4);
    for (int i = 0; i < N; i++) begin
      check($sformatf("t1_hs%0d_cycle", i), 32'(hs_cyc[i] - t0), 32'(2 + 2 * i));
      check($sformatf("t1_hs%0d_data", i), 32'(hs_dat[i]), 32'(pix[i]));
    end
    check("t1_done_cycle", 32'(done_cyc[0] - t0), 32'd26);
    check("t1_done_busy", 32'(done_busy[0]), 32'd0);
    check("t1_done_count", 32'(done_cyc.size()), 32'd1);

    // Serializer stalls on pixel 1 for five cycles.
    clear_logs();
    pulse_start(t0);
    for (int k = 0; k < 80 && done_cyc.size() < 1; k++) begin
      pix_ready = !(cyc >= t0 + 4 && cyc <= t0 + 8);
      if (!pix_ready) begin
        @(negedge clk);
        check("t2_stall_valid", 32'(pix_valid), 32'd1);
        check("t2_stall_data", 32'(pix_data), 32'(pix[1]));
      end
      step();
    end
    pix_ready = 1'b1;
    repeat (5) step();
    check("t2_hs_count", 32'(hs_cyc.size()), 32'd4);
    check("t2_hs1_cycle", 32'(hs_cyc[1] - t0), 32'd9);
    check("t2_hs1_data", 32'(hs_dat[1]), 32'(pix[1]));

    // Serializer still busy after the last pixel.
    clear_logs();
    pulse_start(t0);
    for (int k = 0; k < 80 && done_cyc.size() < 1; k++) begin
      ser_idle = !(cyc >= t0 + 9 && cyc <= t0 + 18);
      step();
    end
    ser_idle = 1'b1;
    repeat (5) step();
    check("t3_done_cycle", 32'(done_cyc[0] - t0), 32'd36);

    // Three requests while busy collapse into one back-to-back frame.
    clear_logs();
    pulse_start(t0);
    for (int k = 0; k < 150 && done_cyc.size() < 2; k++) begin
      frame_start = (cyc == t0 + 5) || (cyc == t0 + 12) || (cyc == t0 + 20);
      step();
    end
    frame_start = 1'b0;
    repeat (60) step();
    check("t4_done_count", 32'(done_cyc.size()), 32'd2);
    check("t4_done0_cycle", 32'(done_cyc[0] - t0), 32'd26);
    check("t4_done0_busy", 32'(done_busy[0]), 32'd1);
    check("t4_done1_cycle", 32'(done_cyc[1] - t0), 32'd51);
    check("t4_done1_busy", 32'(done_busy[1]), 32'd0);
    check("t4_busy_rises", 32'(rise_cyc.size()), 32'd1);
    check("t4_hs_count", 32'(hs_cyc.size()), 32'd8);

    // Request on the final gap cycle.
    clear_logs();
    pulse_start(t0);
    for (int k = 0; k < 150 && done_cyc.size() < 2; k++) begin
      frame_start = (cyc == t0 + 25);
      step();
    end
    frame_start = 1'b0;
    repeat (5) step();
    check("t4b_done1_cycle", 32'(done_cyc[1] - t0), 32'd51);
    check("t4b_busy_rises", 32'(rise_cyc.size()), 32'd1);

    // Auto refresh for 1000 cycles.
    clear_logs();
    auto_en = 1'b1;
    a0 = cyc;
    repeat (1000) step();
    auto_en = 1'b0;
    repeat (40) step();
    check("t5_frames", 32'(rise_cyc.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t5_start%0d", i), 32'(rise_cyc[i] - a0), 32'(200 * (i + 1)));
    end

    // Dropping auto_en for one cycle restarts the refresh period.
    clear_logs();
    a0 = cyc;
    auto_en = 1'b1;
    repeat (150) step();
    auto_en = 1'b0;
    step();
    auto_en = 1'b1;
    repeat (250) step();
    auto_en = 1'b0;
    repeat (40) step();
    check("t5_restart_frames", 32'(rise_cyc.size()), 32'd1);
    check("t5_restart_start", 32'(rise_cyc[0] - a0), 32'd351);

    // Reset while pixel 2 is on offer, then an out-of-range write.
    clear_logs();
    pulse_start(t0);
    for (int k = 0; k < 20 && cyc <= t0 + 7; k++) begin
      pix_ready = (cyc < t0 + 6);
      rst = (cyc == t0 + 7);
      step();
    end
    check_idle_outputs("t6_after_rst");
    rst = 1'b0;
    pix_ready = 1'b1;
    repeat (40) step();
    check("t6_no_done", 32'(done_cyc.size()), 32'd0);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 24'hABCDEF;
    step();
    wr_en = 1'b0;
    clear_logs();
    pulse_start(t0);
    wait_done(1, 100);
    for (int i = 0; i < N; i++) begin
      check($sformatf("t6_hs%0d_data", i), 32'(hs_dat[i]), 32'(pix[i]));
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      rst         = ($urandom_range(0, 499) == 0);
      wr_en       = ($urandom_range(0, 4) == 0);
      wr_addr     = AW'($urandom_range(0, 7));
      wr_data     = 24'($urandom);
      frame_start = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
      pix_ready   = ($urandom_range(0, 9) < 7);
      ser_idle    = ($urandom_range(0, 9) < 8);
      step();
    end
    rst = 1'b0; wr_en = 1'b0; frame_start = 1'b0; auto_en = 1'b0;
    pix_ready = 1'b1; ser_idle = 1'b1;
    repeat (60) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
